// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: an in-order circular queue of
// {instr, pc} entries with a valid/ready head, redirect flush and NOP fill.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc_nxt,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full    = (r_cnt == CW'(DEPTH));
  // in_ready looks only at rst and registered occupancy, so a full queue
  // refuses a push even when the head is being popped in the same cycle.
  assign in_ready  = rst & ~w_full;
  assign out_valid = (r_cnt != '0);
  assign level     = r_cnt;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read while
  // the occupancy counter marks it valid, so its contents after reset never matter.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= in_instr;
      r_pc_mem[r_wr_ptr]    <= in_pc;
    end
  end

  // NOTE: defaults come first so every path assigns every output and no
  // latch is inferred.
  always_comb begin
    out_instr  = NOP;
    out_pc     = '0;
    out_pc_nxt = '0;
    if (out_valid) begin
      out_instr  = r_instr_mem[r_rd_ptr];
      out_pc     = r_pc_mem[r_rd_ptr];
      out_pc_nxt = r_pc_mem[r_rd_ptr] + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic compared against a queue-based model of the buffer.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_nxt;
  logic          out_ready;
  logic [LW-1:0] level;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t mq[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_pc_nxt (out_pc_nxt),
    .out_ready  (out_ready),
    .level      (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  // Model: applies the queue rules to the inputs seen at the edge.
  task automatic cycle();
    bit acc;
    bit deq;
    @(posedge clk);
    acc = in_valid && rst && (mq.size() < DEPTH) && !flush;
    deq = (mq.size() != 0) && out_ready && !flush;
    if (!rst || flush) begin
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (acc) mq.push_back('{instr: in_instr, pc: in_pc});
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
  endtask

  task automatic clear_queue();
    idle_inputs();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    settle();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready_low: got %0b required 0", in_ready);
    end
    cycle();
    cycle();
    rst = 1'b1;
    settle();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'd0 ||
        out_pc_nxt !== 32'd0 || level !== LW'(0)) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b instr=%h pc=%h nxt=%h lvl=%0d required v=0 instr=%h pc=0 nxt=0 lvl=0",
               out_valid, out_instr, out_pc, out_pc_nxt, level, NOP);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_fill_block();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_pc    = 32'(k);
      in_instr = 32'h0021_8193 + 32'(k);
      cycle();
      settle();
      checks++;
      if (level !== LW'(k)) begin
        failures++;
        $display("FAIL fill_level_%0d: got %0d required %0d", k, level, k);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full_in_ready: got %0b required 0", in_ready);
    end
    in_pc    = 32'd5;
    in_instr = 32'h0021_8198;
    cycle();
    settle();
    checks++;
    if (level !== LW'(4) || out_pc !== 32'd1 || out_pc_nxt !== 32'd2 ||
        out_instr !== 32'h0021_8194) begin
      failures++;
      $display("FAIL fill_blocked_head: got lvl=%0d pc=%h nxt=%h instr=%h required lvl=4 pc=1 nxt=2 instr=00218194",
               level, out_pc, out_pc_nxt, out_instr);
    end
  endtask

  task automatic test_full_pop();
    in_valid  = 1'b1;
    in_pc     = 32'd5;
    in_instr  = 32'h0021_8198;
    out_ready = 1'b1;
    cycle();
    settle();
    checks++;
    if (level !== LW'(3) || out_pc !== 32'd2) begin
      failures++;
      $display("FAIL full_pop_refuse: got lvl=%0d head=%h required lvl=3 head=2", level, out_pc);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_reopen: got %0b required 1", in_ready);
    end
    out_ready = 1'b0;
    cycle();
    settle();
    checks++;
    if (level !== LW'(4)) begin
      failures++;
      $display("FAIL full_pop_accept: got lvl=%0d required 4", level);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    settle();
    checks++;
    if (level !== LW'(3)) begin
      failures++;
      $display("FAIL flush_setup_level: got %0d required 3", level);
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'd99;
    in_instr  = 32'hDEAD_0001;
    out_ready = 1'b1;
    cycle();
    idle_inputs();
    settle();
    checks++;
    if (level !== LW'(0) || out_valid !== 1'b0 || out_instr !== NOP ||
        out_pc !== 32'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got lvl=%0d v=%0b instr=%h pc=%h rdy=%0b required lvl=0 v=0 instr=%h pc=0 rdy=1",
               level, out_valid, out_instr, out_pc, in_ready, NOP);
    end
    in_valid = 1'b1;
    in_pc    = 32'h40;
    in_instr = 32'h0040_0093;
    cycle();
    in_valid = 1'b0;
    settle();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_pc_nxt !== 32'h41 ||
        out_instr !== 32'h0040_0093) begin
      failures++;
      $display("FAIL flush_redirect_head: got v=%0b pc=%h nxt=%h instr=%h required v=1 pc=40 nxt=41 instr=00400093",
               out_valid, out_pc, out_pc_nxt, out_instr);
    end
  endtask

  task automatic test_stream_wrap();
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    int          lvl_bad = 0;
    clear_queue();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(i);
      in_instr = 32'h1000_0000 ^ (32'(i) * 32'h0101_0101);
      settle();
      if (i > 0 && level !== LW'(1)) lvl_bad++;
      if (out_valid) begin
        got_pc.push_back(out_pc);
        got_instr.push_back(out_instr);
      end
      cycle();
    end
    in_valid = 1'b0;
    settle();
    if (level !== LW'(1)) lvl_bad++;
    if (out_valid) begin
      got_pc.push_back(out_pc);
      got_instr.push_back(out_instr);
    end
    cycle();
    out_ready = 1'b0;
    checks++;
    if (lvl_bad != 0) begin
      failures++;
      $display("FAIL stream_level: got %0d cycles with level!=1 required 0", lvl_bad);
    end
    checks++;
    if (got_pc.size() != 12) begin
      failures++;
      $display("FAIL stream_count: got %0d words required 12", got_pc.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (got_pc[i] !== 32'(i) ||
            got_instr[i] !== (32'h1000_0000 ^ (32'(i) * 32'h0101_0101))) begin
          failures++;
          $display("FAIL stream_word_%0d: got pc=%h instr=%h required pc=%h instr=%h", i,
                   got_pc[i], got_instr[i], 32'(i), 32'h1000_0000 ^ (32'(i) * 32'h0101_0101));
        end
      end
    end
  endtask

  task automatic test_pc_wrap();
    clear_queue();
    in_valid = 1'b1;
    in_pc    = 32'hFFFF_FFFF;
    in_instr = 32'h0000_006F;
    cycle();
    in_valid = 1'b0;
    settle();
    checks++;
    if (out_pc !== 32'hFFFF_FFFF || out_pc_nxt !== 32'd0) begin
      failures++;
      $display("FAIL pc_nxt_wrap: got pc=%h nxt=%h required pc=ffffffff nxt=00000000", out_pc, out_pc_nxt);
    end
  endtask

  task automatic test_reset_mid();
    clear_queue();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_pc    = 32'h80 + 32'(k);
      in_instr = 32'hABC0_0000 + 32'(k);
      cycle();
    end
    settle();
    checks++;
    if (level !== LW'(2)) begin
      failures++;
      $display("FAIL reset_mid_setup: got lvl=%0d required 2", level);
    end
    rst      = 1'b0;
    in_pc    = 32'h90;
    in_instr = 32'h1234_5678;
    settle();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_in_ready: got %0b required 0", in_ready);
    end
    cycle();
    rst      = 1'b1;
    in_valid = 1'b0;
    settle();
    checks++;
    if (level !== LW'(0) || out_valid !== 1'b0 || out_instr !== NOP) begin
      failures++;
      $display("FAIL reset_mid_cleared: got lvl=%0d v=%0b instr=%h required lvl=0 v=0 instr=%h",
               level, out_valid, out_instr, NOP);
    end
  endtask

  task automatic test_random();
    int          bad = 0;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_nxt;
    logic        e_ready;
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = $urandom;
      in_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      settle();
      e_valid = (mq.size() != 0);
      e_instr = e_valid ? mq[0].instr : NOP;
      e_pc    = e_valid ? mq[0].pc : 32'd0;
      e_nxt   = e_valid ? mq[0].pc + 32'd1 : 32'd0;
      e_ready = rst && (mq.size() < DEPTH);
      checks++;
      if (out_valid !== e_valid || out_instr !== e_instr || out_pc !== e_pc ||
          out_pc_nxt !== e_nxt || in_ready !== e_ready || level !== LW'(mq.size())) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: got v=%0b instr=%h pc=%h nxt=%h rdy=%0b lvl=%0d required v=%0b instr=%h pc=%h nxt=%h rdy=%0b lvl=%0d",
                   n, out_valid, out_instr, out_pc, out_pc_nxt, in_ready, level,
                   e_valid, e_instr, e_pc, e_nxt, e_ready, mq.size());
      end
      cycle();
    end
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_fill_block();
    test_full_pop();
    test_flush();
    test_stream_wrap();
    test_pc_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and decode. It captures each fetched instruction word together with its word-indexed PC, and holds up to DEPTH entries in order. It presents the oldest entry to decode through a valid/ready handshake, and it discards all buffered entries when a control-flow redirect occurs. When no entry is available, decode sees a NOP, so decode never consumes a stale word.

## Interface

- DEPTH, 4, number of entries; power of two, minimum 2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk, and rst=0 resets the block
- flush  input  1  redirect (taken branch/jump); discards every entry
- in_valid  input  1  fetch presents a word this cycle
- in_instr  input  32  fetched instruction
- in_pc  input  32  word address of in_instr
- in_ready  output  1  queue can accept a word this cycle
- out_valid  output  1  head entry is valid
- out_instr  output  32  head instruction, or NOP 0x00000013 when out_valid=0
- out_pc  output  32  head PC, or 0 when out_valid=0
- out_pc_nxt  output  32  out_pc + 1 (word increment, mod 2^32), or 0 when out_valid=0
- out_ready  input  1  decode accepts the head entry this cycle
- level  output  log2(DEPTH)+1  number of occupied entries

## Operation

- Storage: circular array of DEPTH entries. Each entry holds {instr, pc}.
- Pointers: write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits, wrap modulo DEPTH. The occupancy counter cnt is the register behind level.
- push = in_valid & in_ready & ~flush. On push, write {in_instr, in_pc} at wr_ptr, then wr_ptr+1.
- pop = out_valid & out_ready & ~flush. On pop, rd_ptr+1.
- Count update: cnt_next = cnt + push − pop. Push and pop in the same cycle leave cnt unchanged, and both pointers advance.
- in_ready = rst & (cnt != DEPTH). It is combinational from registered state only, and has no dependence on out_ready. A full queue therefore refuses a push even when a pop occurs in the same cycle.
- out_valid = (cnt != 0). Head outputs are driven directly from storage at rd_ptr; they are not registered again.
- NOP substitution: when cnt=0, out_instr=0x00000013, out_pc=0, out_pc_nxt=0.
- Flush:
  - cnt←0, rd_ptr←wr_ptr. Storage contents are left unchanged.
  - Flush takes priority: a same-cycle push is dropped and a same-cycle pop is ignored.
  - The redirected fetch word arrives in a later cycle, as a normal push.
- Priority order: rst (low) > flush > push/pop.
- Pop when empty and push when full cannot occur: by construction, pop requires out_valid and push requires in_ready.

## Timing

- Reset (rst=0 at a clock edge):
  - cnt=0, wr_ptr=0, rd_ptr=0.
  - Outputs after reset: out_valid=0, out_instr=0x00000013, out_pc=0, out_pc_nxt=0, level=0.
  - in_ready=0 during every cycle in which rst=0, and 1 in the first cycle after rst returns to 1.
- Reset mid-operation discards all entries, exactly like a flush, and also re-zeroes both pointers.
- Latency: a word pushed at edge N is visible on out_* with out_valid=1 in the cycle after edge N. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle when 0 < cnt < DEPTH.
  - At cnt=DEPTH, fetch is blocked for one cycle.
  - That cycle's pop then reopens in_ready in the next cycle.
- Flush at edge N: out_valid=0 and level=0 in the cycle after edge N. in_ready=1 in that same cycle.
- Pointer wrap: after index DEPTH−1, the next pointer value is 0, with no bubble.
- out_pc_nxt wraps from 0xFFFFFFFF to 0x00000000.
- Handshake stability: while out_valid=1 and out_ready=0, out_instr, out_pc and out_pc_nxt stay constant.

## Test plan

- Reset then idle: hold rst=0 for 2 cycles, then rst=1 with in_valid=0 → out_valid=0, out_instr=0x00000013, out_pc=0, level=0, in_ready=1.
- Fill and block: push pc 1..4 with instr 0x00218193+k and out_ready=0 → level climbs to 4 and in_ready=0. A 5th word offered at pc 5 is not accepted. out_pc stays at 1, with out_pc_nxt=2.
- Streaming with wrap: drive in_valid=1 and out_ready=1 continuously for 12 words, pc 0..11 → decode receives pc 0..11 in order with matching instr, and no duplicates or drops across two pointer wraps. After the first word, level holds at 1.
- Full with simultaneous pop: at level=4, assert out_ready=1 and in_valid=1 → the head pops and the push is refused, so level=3. In the next cycle in_ready=1 and the push is accepted.
- Flush with concurrent push/pop: level=3, then flush=1 with in_valid=1 and out_ready=1 in one cycle → next cycle level=0, out_valid=0 and out_instr=NOP. A following push of pc 0x40 appears as the head one cycle later.
- Reset mid-operation: level=2, then rst=0 for one cycle with in_valid=1 → level=0, out_valid=0, and in_ready=0 during that reset cycle. The pushed word is discarded.
